// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first ripple through one full-adder slice per clock.
// Optional subtract support is enabled with the SERIAL_ADDER_SUB_EN macro.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             V,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] a_q, b_q;
    logic            cy;
    logic            accept;
    logic            last;
    logic            sum_bit;
    logic            cout;
    logic [WIDTH-1:0] b_eff;
    logic            cin_eff;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is A + ~B + 1, so the forced carry-in replaces Cin.
    assign b_eff   = sub ? ~B : B;
    assign cin_eff = sub ? 1'b1 : Cin;
`else
    assign b_eff   = B;
    assign cin_eff = Cin;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        busy     = (state == ADD);
        done     = (state == DONE);
        last     = (cnt == LAST);
        sum_bit  = a_q[0] ^ b_q[0] ^ cy;
        cout     = (a_q[0] & b_q[0]) | (cy & (a_q[0] ^ b_q[0]));
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ADD;
                    accept   = 1'b1;
                end
            end
            ADD: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                if (start) begin
                    state_nx = ADD;
                    accept   = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operands and S shift right each step so the slice always works on bit 0
    // and the finished sum lands in order after WIDTH steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            cy  <= 1'b0;
            cnt <= '0;
            S   <= '0;
            C   <= 1'b0;
            V   <= 1'b0;
        end else if (accept) begin
            a_q <= A;
            b_q <= b_eff;
            cy  <= cin_eff;
            cnt <= '0;
        end else if (state == ADD) begin
            a_q <= a_q >> 1;
            b_q <= b_q >> 1;
            S   <= {sum_bit, S[WIDTH-1:1]};
            cy  <= cout;
            cnt <= cnt + CW'(1);
            if (last) begin
                C <= cout;
                V <= cy ^ cout;
            end
        end
    end

endmodule
